// File: rtl/constellation_demap.sv
// Integrate-and-dump QPSK/16-QAM hard demapper: sums SPS samples per symbol on I and Q,
// then slices the sums against zero and a fixed amplitude threshold into 4 bits.
module constellation_demap #(
    parameter int W   = 16,
    parameter int SPS = 4,
    parameter int AMP = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mod_type,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_align,
    input  logic signed [W-1:0] sample_I,
    input  logic signed [W-1:0] sample_Q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_symbol,
    output logic [15:0]         sym_count
);

    localparam int LOG_SPS = $clog2(SPS);
    localparam int AW      = W + LOG_SPS;
    localparam int PW      = (SPS > 1) ? LOG_SPS : 1;
    localparam logic signed [AW-1:0] THRESH = AW'(2 * AMP * SPS);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic signed [AW-1:0]  acc_i_q, acc_q_q;
    logic signed [AW-1:0]  sum_i, sum_q;
    logic signed [AW-1:0]  ext_i, ext_q;
    logic                  mod_q, mod_sel;
    logic                  accept, first, complete;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    assign ext_i = AW'(sample_I);
    assign ext_q = AW'(sample_Q);

    // An aligned sample restarts the symbol exactly like a phase-0 sample does.
    assign first    = in_align || (phase_q == '0);
    assign sum_i    = first ? ext_i : acc_i_q + ext_i;
    assign sum_q    = first ? ext_q : acc_q_q + ext_q;
    assign mod_sel  = first ? mod_type : mod_q;
    assign complete = accept && (first ? (SPS == 1) : (phase_q == PW'(SPS - 1)));

    function automatic logic [3:0] decode(input logic signed [AW-1:0] ai,
                                          input logic signed [AW-1:0] aq,
                                          input logic                 qam);
        logic [3:0] s;
        s[3] = (ai < 0);
        s[2] = (aq < 0);
        s[1] = qam && ((ai > THRESH) || (ai < -THRESH));
        s[0] = qam && ((aq > THRESH) || (aq < -THRESH));
        return s;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        phase_d = phase_q;
        state_d = state_q;
        if (accept) begin
            if (complete)   phase_d = '0;
            else if (first) phase_d = PW'(1);
            else            phase_d = phase_q + PW'(1);
        end
        case (state_q)
            EMPTY:   if (complete) state_d = FULL;
            FULL:    if (!complete && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            phase_q    <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            mod_q      <= 1'b0;
            out_symbol <= 4'd0;
            sym_count  <= 16'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (accept) begin
                acc_i_q <= sum_i;
                acc_q_q <= sum_q;
                if (first) mod_q <= mod_type;
            end
            if (complete) out_symbol <= decode(sum_i, sum_q, mod_sel);
            if (out_valid && out_ready) sym_count <= sym_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_constellation_demap.sv
// Random and directed stimulus for constellation_demap, checked against a queue-based
// model that sums each symbol's samples as integers and slices them by the decision rules.
module tb_constellation_demap;

    localparam int W   = 16;
    localparam int SPS = 4;
    localparam int AMP = 1024;
    localparam int T   = 2 * AMP * SPS;

    logic                clk = 1'b0;
    logic                rst;
    logic                mod_type;
    logic                in_valid;
    logic                in_ready;
    logic                in_align;
    logic signed [W-1:0] sample_I;
    logic signed [W-1:0] sample_Q;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_symbol;
    logic [15:0]         sym_count;

    constellation_demap #(.W(W), .SPS(SPS), .AMP(AMP)) dut (
        .clk(clk), .rst(rst), .mod_type(mod_type),
        .in_valid(in_valid), .in_ready(in_ready), .in_align(in_align),
        .sample_I(sample_I), .sample_Q(sample_Q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_symbol(out_symbol), .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int         cur_i[$];
    int         cur_q[$];
    bit         cur_mod;
    logic [3:0] exp_q[$];
    int         model_count = 0;
    logic [3:0] last_sym;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_symbol(input int si, input int sq, input bit qam);
        logic [3:0] s;
        s[3] = si < 0;
        s[2] = sq < 0;
        s[1] = qam && (si > T || si < -T);
        s[0] = qam && (sq > T || sq < -T);
        return s;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit v, input bit al, input bit md, input int si, input int sq,
                        input bit ordy, input bit r, output bit acc);
        bit dlv;
        int ti, tq;
        in_valid  = v;
        in_align  = al;
        mod_type  = md;
        sample_I  = W'(si);
        sample_Q  = W'(sq);
        out_ready = ordy;
        rst       = r;
        #1;
        acc = v && ((exp_q.size() == 0) || ordy) && !r;
        dlv = (exp_q.size() != 0) && ordy && !r;
        check("in_ready", in_ready, (exp_q.size() == 0) || ordy);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("out_symbol", out_symbol, exp_q[0]);
        check("sym_count", sym_count, model_count);
        if (dlv) last_sym = out_symbol;
        @(posedge clk);
        if (r) begin
            cur_i.delete();
            cur_q.delete();
            exp_q.delete();
            model_count = 0;
        end else begin
            if (dlv) begin
                void'(exp_q.pop_front());
                model_count = (model_count + 1) % 65536;
            end
            if (acc) begin
                if (al) begin
                    cur_i.delete();
                    cur_q.delete();
                end
                if (cur_i.size() == 0) cur_mod = md;
                cur_i.push_back(si);
                cur_q.push_back(sq);
                if (cur_i.size() == SPS) begin
                    ti = 0;
                    tq = 0;
                    foreach (cur_i[k]) begin
                        ti += cur_i[k];
                        tq += cur_q[k];
                    end
                    exp_q.push_back(ref_symbol(ti, tq, cur_mod));
                    cur_i.delete();
                    cur_q.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input bit al, input bit md, input int si, input int sq);
        bit ok;
        int tries = 0;
        do begin
            step(1'b1, al, md, si, sq, 1'b1, 1'b0, ok);
            tries++;
        end while (!ok && tries < 50);
        if (!ok) check("send_timeout", 0, 1);
    endtask

    // Full aligned symbol; mod_type flips after the first sample and must be ignored.
    task automatic sym4(input bit md, input int si, input int sq);
        send(1'b1, md, si, sq);
        repeat (SPS - 1) send(1'b0, !md, si, sq);
    endtask

    task automatic idle();
        bit ok;
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, ok);
    endtask

    initial begin
        bit ok;
        int base;
        rst = 1'b1; in_valid = 1'b0; in_align = 1'b0; mod_type = 1'b0;
        sample_I = '0; sample_Q = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_symbol", out_symbol, 0);
        check("rst_sym_count", sym_count, 0);
        check("rst_in_ready", in_ready, 1);

        last_sym = 4'hA;
        sym4(1'b1, 3072, -1024);
        idle();
        check("sym_0110", last_sym, 4'b0110);
        check("count_after_first", sym_count, 1);

        last_sym = 4'hA;
        sym4(1'b1, 2048, 2048);
        idle();
        check("sym_at_threshold", last_sym, 4'b0000);
        last_sym = 4'hA;
        sym4(1'b1, 0, 0);
        idle();
        check("sym_zero", last_sym, 4'b0000);

        last_sym = 4'hA;
        sym4(1'b0, -3072, 3072);
        idle();
        check("sym_qpsk_1000", last_sym, 4'b1000);

        sym4(1'b1, 3072, 3072);
        repeat (10) step(1'b1, 1'b0, 1'b1, -3072, -3072, 1'b0, 1'b0, ok);
        check("stall_held", out_symbol, 4'b0011);
        last_sym = 4'hA;
        sym4(1'b0, -3072, 3072);
        idle();
        check("after_stall", last_sym, 4'b1000);

        base = model_count;
        send(1'b1, 1'b1, 3072, 3072);
        send(1'b0, 1'b1, 3072, 3072);
        last_sym = 4'hA;
        sym4(1'b1, -3072, -3072);
        idle();
        check("realign_sym", last_sym, 4'b1111);
        check("realign_single", sym_count, (base + 1) % 65536);

        send(1'b1, 1'b1, 3072, 3072);
        send(1'b0, 1'b1, 3072, 3072);
        send(1'b0, 1'b1, 3072, 3072);
        step(1'b1, 1'b0, 1'b1, 3072, 3072, 1'b1, 1'b1, ok);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_count", sym_count, 0);
        step(1'b1, 1'b0, 1'b1, 3072, 3072, 1'b1, 1'b1, ok);
        last_sym = 4'hA;
        send(1'b0, 1'b1, 1024, 1024);
        repeat (SPS - 1) send(1'b0, 1'b1, 1024, 1024);
        idle();
        check("post_rst_sym", last_sym, 4'b0000);
        check("post_rst_count", sym_count, 1);

        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0, ok);
        end
        repeat (3) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
